sar_search_nb: RTL and testbench

- Sequential binary-search engine that drives the B operand of an external n-bit magnitude comparator and consumes its EQ/LT/GT result.
- Locates an unknown target value, held on the comparator's A input, within a programmable inclusive range [lo_in, hi_in].
- Used by step-size and threshold logic in the solver datapath to invert a monotonic compare into a value.
- The comparator is combinational. One probe is issued and evaluated per clock.

---
 rtl/sar_search_nb.sv | 130 +++++++++++++
 tb/tb_sar_search_nb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sar_search_nb.sv
// Binary-search engine: drives the B operand of an external combinational
// comparator and narrows [lo,hi] each clock until the target is located.
module sar_search_nb #(
  parameter int n  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [n-1:0]  lo_in,
  input  logic [n-1:0]  hi_in,
  output logic [n-1:0]  probe,
  input  logic          eq,
  input  logic          lt,
  input  logic          gt,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [n-1:0]  result,
  output logic          err,
  output logic [CW-1:0] iters
);

  typedef enum logic [1:0] {IDLE, PROBE, FIN} state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [n-1:0]  probe_q, probe_d, result_q, result_d;
  logic          found_q, found_d, err_q, err_d;
  logic [CW-1:0] iters_q, iters_d;

  logic          onehot;
  logic [n-1:0]  probe_inc, probe_dec, mid_gt, mid_lt, mid_start;

  assign onehot    = (eq ^ lt ^ gt) & ~(eq & lt & gt);
  assign probe_inc = probe_q + 1'b1;
  assign probe_dec = probe_q - 1'b1;
  // Midpoints of the narrowed range; probe==lo/hi exits keep these from wrapping.
  assign mid_gt    = probe_inc + ((hi_q - probe_inc) >> 1);
  assign mid_lt    = lo_q + ((probe_dec - lo_q) >> 1);
  assign mid_start = lo_in + ((hi_in - lo_in) >> 1);

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    probe_d  = probe_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    iters_d  = iters_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          lo_d     = lo_in;
          hi_d     = hi_in;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          iters_d  = '0;
          if (lo_in > hi_in) begin
            state_d = FIN;
          end else begin
            probe_d = mid_start;
            state_d = PROBE;
          end
        end
      end
      PROBE: begin
        iters_d = iters_q + 1'b1;
        if (!onehot) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = FIN;
        end else if (eq) begin
          found_d  = 1'b1;
          result_d = probe_q;
          state_d  = FIN;
        end else if (gt) begin
          if (probe_q == hi_q) begin
            state_d = FIN;
          end else begin
            lo_d    = probe_inc;
            probe_d = mid_gt;
          end
        end else begin
          if (probe_q == lo_q) begin
            state_d = FIN;
          end else begin
            hi_d    = probe_dec;
            probe_d = mid_lt;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      iters_q  <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
      iters_q  <= iters_d;
    end
  end

  assign probe  = probe_q;
  assign busy   = (state_q == PROBE);
  assign done   = (state_q == FIN);
  assign found  = found_q;
  assign result = result_q;
  assign err    = err_q;
  assign iters  = iters_q;

endmodule

// File: tb/tb_sar_search_nb.sv
// Directed bench for sar_search_nb (n=8): a behavioural comparator answers
// each probe; vectors carry hand-derived probe sequences and outcomes.
module tb_sar_search_nb;

  localparam int N  = 8;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  lo_in, hi_in;
  logic [N-1:0]  probe;
  logic          eq, lt, gt;
  logic          busy, done, found, err;
  logic [N-1:0]  result;
  logic [CW-1:0] iters;

  logic [N-1:0]  target;
  logic          force_bad;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign eq = force_bad ? 1'b1 : (target == probe);
  assign lt = force_bad ? 1'b1 : (target <  probe);
  assign gt = force_bad ? 1'b0 : (target >  probe);

  sar_search_nb #(.n(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lo_in(lo_in), .hi_in(hi_in),
    .probe(probe), .eq(eq), .lt(lt), .gt(gt), .busy(busy), .done(done),
    .found(found), .result(result), .err(err), .iters(iters)
  );

  typedef struct {
    logic [N-1:0]        lo, hi, tgt;
    logic [0:8][N-1:0]   seq;
    logic                fnd;
    logic [N-1:0]        res;
    int                  it;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic launch(input logic [N-1:0] lo, input logic [N-1:0] hi, input logic [N-1:0] tgt);
    target = tgt;
    lo_in  = lo;
    hi_in  = hi;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Cycles from the accepting edge to done must equal the probe count.
  task automatic run_vec(input int i);
    vec_t v;
    int   cyc, idx;
    bit   seq_ok;
    v = vecs[i];
    launch(v.lo, v.hi, v.tgt);
    cyc = 0; idx = 0; seq_ok = 1'b1;
    while (!done && cyc < 30) begin
      if (busy) begin
        if (idx >= v.it) seq_ok = 1'b0;
        else if (probe != v.seq[idx]) seq_ok = 1'b0;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk($sformatf("v%0d_latency", i), cyc, v.it);
    chk($sformatf("v%0d_probe_seq", i), {31'd0, seq_ok}, 1);
    chk($sformatf("v%0d_nprobes", i), idx, v.it);
    chk($sformatf("v%0d_found", i), found, v.fnd);
    chk($sformatf("v%0d_result", i), result, v.res);
    chk($sformatf("v%0d_err", i), err, 0);
    chk($sformatf("v%0d_iters", i), iters, v.it);
    chk($sformatf("v%0d_busy_in_fin", i), busy, 0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_one_cycle", i), done, 0);
    chk($sformatf("v%0d_found_hold", i), found, v.fnd);
  endtask

  initial begin
    int cyc, pulses;
    vecs[0] = '{8'd0,   8'd100, 8'd37,  {8'd50, 8'd24, 8'd37, 48'd0}, 1'b1, 8'd37, 3};
    vecs[1] = '{8'd9,   8'd3,   8'd5,   72'd0, 1'b0, 8'd0, 0};
    vecs[2] = '{8'd0,   8'd255, 8'd255, {8'd127, 8'd191, 8'd223, 8'd239, 8'd247,
                                         8'd251, 8'd253, 8'd254, 8'd255}, 1'b1, 8'd255, 9};
    vecs[3] = '{8'd0,   8'd255, 8'd0,   {8'd127, 8'd63, 8'd31, 8'd15, 8'd7,
                                         8'd3, 8'd1, 8'd0, 8'd0}, 1'b1, 8'd0, 8};
    vecs[4] = '{8'd10,  8'd20,  8'd5,   {8'd15, 8'd12, 8'd10, 48'd0}, 1'b0, 8'd0, 3};
    vecs[5] = '{8'd5,   8'd5,   8'd5,   {8'd5, 64'd0}, 1'b1, 8'd5, 1};
    vecs[6] = '{8'd200, 8'd210, 8'd250, {8'd205, 8'd208, 8'd209, 8'd210, 40'd0}, 1'b0, 8'd0, 4};

    rst_n = 1'b0; start = 1'b0; lo_in = '0; hi_in = '0; target = '0; force_bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_probe", probe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_iters", iters, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Non-one-hot flags on the first probe.
    force_bad = 1'b1;
    launch(8'd0, 8'd255, 8'd77);
    wait_done(cyc);
    chk("bad_latency", cyc, 1);
    chk("bad_err", err, 1);
    chk("bad_found", found, 0);
    chk("bad_iters", iters, 1);
    force_bad = 1'b0;
    @(posedge clk); #1;

    // start while busy must not disturb the running search.
    launch(8'd0, 8'd100, 8'd37);
    @(posedge clk); #1;
    lo_in = 8'd200; hi_in = 8'd210; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    chk("busy_start_latency", cyc, 1);
    chk("busy_start_found", found, 1);
    chk("busy_start_result", result, 37);
    chk("busy_start_iters", iters, 3);
    @(posedge clk); #1;

    // Asynchronous reset during the 2nd probe aborts without a done pulse.
    launch(8'd0, 8'd255, 8'd100);
    @(posedge clk); #1;
    chk("mid_second_probe", probe, 63);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_probe", probe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_iters", iters, 0);
    chk("arst_found", found, 0);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("arst_no_done", pulses, 0);
    run_vec(0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
